// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO driving the register file write port,
// with pending flags so decode can stall reads of still-queued destinations.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memReg,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluReg,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic              pending1,
  output logic              pending2,
  output logic [CW-1:0]     count,
  output logic              full
);
  logic [ADDR_W-1:0] dst_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic reg_write_q;
  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic mem_push, alu_push, pop;
  logic [DEPTH-1:0] hit1, hit2;
  assign memReady = count_q < CW'(DEPTH);
  assign aluReady = count_q <= CW'(DEPTH - 2) || (memReady && !memValid);
  // register 0 completes the handshake but is never stored
  assign mem_push = memValid && memReady && memReg != '0;
  assign alu_push = aluValid && aluReady && aluReg != '0;
  assign pop = count_q != '0;
  assign wptr_d = wptr_q + AW'(mem_push) + AW'(alu_push);
  assign rptr_d = rptr_q + AW'(pop);
  assign count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  always_ff @(posedge clk) begin
    if (mem_push) begin
      dst_q[wptr_q] <= memReg;
      dat_q[wptr_q] <= memData;
    end
    if (alu_push) begin
      dst_q[wptr_q + AW'(mem_push)] <= aluReg;
      dat_q[wptr_q + AW'(mem_push)] <= aluData;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      write_data_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      reg_write_q <= pop;
      if (pop) begin
        write_reg_q <= dst_q[rptr_q];
        write_data_q <= dat_q[rptr_q];
      end
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [AW-1:0] off;
    assign off = AW'(i) - rptr_q;
    assign hit1[i] = {1'b0, off} < count_q && dst_q[i] == readReg1;
    assign hit2[i] = {1'b0, off} < count_q && dst_q[i] == readReg2;
  end
  assign pending1 = readReg1 != '0 && (|hit1 || (reg_write_q && write_reg_q == readReg1));
  assign pending2 = readReg2 != '0 && (|hit2 || (reg_write_q && write_reg_q == readReg2));
  assign regWrite = reg_write_q;
  assign writeReg = write_reg_q;
  assign writeData = write_data_q;
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: scoreboard bench for wb_queue; a queue model of the FIFO
// predicts readies, count, pending flags and every register file write.
module tb_wb_queue;
  logic clk = 1'b0;
  logic rst;
  logic memValid, aluValid, memReady, aluReady, regWrite, pending1, pending2, full;
  logic [4:0] memReg, aluReg, writeReg, readReg1, readReg2;
  logic [31:0] memData, aluData, writeData;
  logic [2:0] count;
  typedef struct packed { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t mq[$];
  logic exp_we = 1'b0;
  logic [4:0] exp_reg = '0;
  logic [31:0] exp_data = '0;
  logic last_ma, last_aa;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  wb_queue dut (
    .clk(clk), .rst(rst),
    .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2), .pending1(pending1), .pending2(pending2),
    .count(count), .full(full)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic pend(input logic [4:0] r);
    logic p;
    p = exp_we && exp_reg == r;
    foreach (mq[k]) if (mq[k].r == r) p = 1'b1;
    return r != 0 && p;
  endfunction
  task automatic step();
    int free;
    logic mr, ar;
    @(negedge clk);
    free = 4 - mq.size();
    mr = free >= 1;
    ar = free >= 2 || (free >= 1 && !memValid);
    check("count", count, mq.size());
    check("full", full, free == 0);
    check("memReady", memReady, mr);
    check("aluReady", aluReady, ar);
    check("regWrite", regWrite, exp_we);
    check("writeReg", writeReg, exp_reg);
    check("writeData", writeData, exp_data);
    check("pending1", pending1, pend(readReg1));
    check("pending2", pending2, pend(readReg2));
    last_ma = memValid && mr;
    last_aa = aluValid && ar;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_we = 1'b0;
      exp_reg = '0;
      exp_data = '0;
    end else begin
      exp_we = mq.size() != 0;
      if (exp_we) begin
        ent_t e;
        e = mq.pop_front();
        exp_reg = e.r;
        exp_data = e.d;
      end
      if (last_ma && memReg != 0) mq.push_back('{memReg, memData});
      if (last_aa && aluReg != 0) mq.push_back('{aluReg, aluData});
    end
    #1;
  endtask
  task automatic drv(input logic mv, input logic [4:0] mrg, input logic [31:0] md,
                     input logic av, input logic [4:0] arg, input logic [31:0] ad);
    memValid = mv; memReg = mrg; memData = md;
    aluValid = av; aluReg = arg; aluData = ad;
    step();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int pushed, mi, ai;
    rst = 1'b1;
    memValid = 0; memReg = 0; memData = 0;
    aluValid = 0; aluReg = 0; aluData = 0;
    readReg1 = 5; readReg2 = 3;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    drv(0, 0, 0, 1, 5, 32'hDEADBEEF);
    idle(4);
    drv(1, 3, 32'h11, 1, 4, 32'h22);
    readReg1 = 4;
    idle(4);
    pushed = 0; mi = 0; ai = 100;
    for (int i = 0; i < 100 && pushed < 16; i++) begin
      readReg1 = 5'(1 + mi % 31);
      readReg2 = 5'(1 + ai % 31);
      drv(1, 5'(1 + mi % 31), 32'hA000 + 32'(mi), 1, 5'(1 + ai % 31), 32'hB000 + 32'(ai));
      if (last_ma) begin mi++; pushed++; end
      if (last_aa) begin ai++; pushed++; end
    end
    check("fill_pushes", pushed, 16);
    idle(6);
    readReg1 = 0; readReg2 = 0;
    drv(0, 0, 0, 1, 0, 32'hFFFF);
    idle(3);
    readReg1 = 6; readReg2 = 15;
    for (int i = 0; i < 10; i++) drv(0, 0, 0, 1, 5'(6 + i), 32'hC0 + 32'(i));
    idle(3);
    readReg1 = 7; readReg2 = 9;
    drv(1, 7, 32'h77, 1, 8, 32'h88);
    drv(1, 9, 32'h99, 1, 10, 32'hAA);
    rst = 1'b1;
    drv(1, 11, 32'hBB, 1, 12, 32'hCC);
    rst = 1'b0;
    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
